division_core: RTL and testbench

- Unsigned integer divider for the calculator datapath: divides a WIDTH-bit dividend Q by a WIDTH-bit divisor M.
- Returns the quotient and remainder, each zero-extended to 2*WIDTH bits.
- Free-running, with no start/done handshake: operands are sampled every rising clock edge and the registered results follow one cycle later.
- Sits between the operand registers and the display/result mux.

---
 rtl/division_core_if.sv | 32 +++
 rtl/division_core.sv | 67 ++++++
 tb/tb_division_core.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/division_core_if.sv
// ============================================================================
// Module   : division_core_if
// Purpose  : Operand and result bundle for the combinational-unrolled divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface division_core_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   Q;
    logic [WIDTH-1:0]   M;
    logic [2*WIDTH-1:0] Quotient;
    logic [2*WIDTH-1:0] Reminder;

    // The operand-register side drives Q/M and consumes results.
    modport master (
        output Q,
        output M,
        input  Quotient,
        input  Reminder
    );

    modport slave (
        input  Q,
        input  M,
        output Quotient,
        output Reminder
    );
endinterface

`default_nettype wire

// File: rtl/division_core.sv
// ============================================================================
// Module   : division_core
// Purpose  : Single-cycle unsigned restoring divider with registered results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module division_core #(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    division_core_if.slave      bus
);

    logic [WIDTH-1:0]   quo_w;
    logic [WIDTH-1:0]   rem_w;
    logic [2*WIDTH-1:0] quotient_d;
    logic [2*WIDTH-1:0] reminder_d;
    logic [2*WIDTH-1:0] quotient_q;
    logic [2*WIDTH-1:0] reminder_q;

    // Unrolled restoring division: the MSB of the trial difference is its sign.
    always_comb begin
        logic [WIDTH:0] part_r;
        logic [WIDTH:0] trial;
        part_r = '0;
        trial  = '0;
        quo_w  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            part_r = {part_r[WIDTH-1:0], bus.Q[i]};
            trial  = part_r - {1'b0, bus.M};
            if (!trial[WIDTH]) begin
                part_r   = trial;
                quo_w[i] = 1'b1;
            end
        end
        rem_w = part_r[WIDTH-1:0];
    end

    // All-ones quotient is unreachable by a legal division, so it flags M == 0.
    always_comb begin
        if (bus.M == '0) begin
            quotient_d = '1;
            reminder_d = {{WIDTH{1'b0}}, bus.Q};
        end else begin
            quotient_d = {{WIDTH{1'b0}}, quo_w};
            reminder_d = {{WIDTH{1'b0}}, rem_w};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_q <= '0;
            reminder_q <= '0;
        end else begin
            quotient_q <= quotient_d;
            reminder_q <= reminder_d;
        end
    end

    assign bus.Quotient = quotient_q;
    assign bus.Reminder = reminder_q;

endmodule

`default_nettype wire

// File: tb/tb_division_core.sv
// ============================================================================
// Module   : tb_division_core
// Purpose  : Scoreboard-driven self-checking bench for division_core (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_division_core;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [2*WIDTH-1:0] q;
        logic [2*WIDTH-1:0] r;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    division_core_if #(.WIDTH(WIDTH)) bus ();

    division_core #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division with the divide-by-zero code.
    task automatic push_expected(input int qv, input int mv);
        exp_t e;
        if (mv == 0) begin
            e.q = 8'hFF;
            e.r = 8'(qv);
        end else begin
            e.q = 8'(qv / mv);
            e.r = 8'(qv % mv);
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int qv, input int mv);
        bus.Q = 4'(qv);
        bus.M = 4'(mv);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(15, 3);
        #1;
        n_checks++;
        if (bus.Quotient !== 8'h00 || bus.Reminder !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_initial: got %h/%h expected 00/00", bus.Quotient, bus.Reminder);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.Quotient !== 8'h00 || bus.Reminder !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: got %h/%h expected 00/00", bus.Quotient, bus.Reminder);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_expected(15, 3);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.Quotient !== e.q || bus.Reminder !== e.r || e.q !== 8'h05) begin
            n_fail++;
            $display("FAIL reset_release: got %h/%h expected %h/%h", bus.Quotient, bus.Reminder, e.q, e.r);
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        int   qs[2] = '{0, 9};
        foreach (qs[k]) begin
            @(negedge clk);
            drive(qs[k], 0);
            push_expected(qs[k], 0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.Quotient !== e.q || bus.Reminder !== e.r) begin
                n_fail++;
                $display("FAIL div_by_zero Q=%0d: got %h/%h expected %h/%h", qs[k], bus.Quotient, bus.Reminder, e.q, e.r);
            end
        end
    endtask

    task automatic test_reference();
        exp_t e;
        int   qs[5] = '{15, 8, 7, 3, 2};
        int   ms[5] = '{15, 2, 2, 2, 7};
        foreach (qs[k]) begin
            @(negedge clk);
            drive(qs[k], ms[k]);
            for (int h = 0; h < 3; h++) begin
                push_expected(qs[k], ms[k]);
                @(posedge clk); #1;
                e = sb.pop_front();
                n_checks++;
                if (bus.Quotient !== e.q || bus.Reminder !== e.r) begin
                    n_fail++;
                    $display("FAIL reference %0d/%0d edge%0d: got %h/%h expected %h/%h", qs[k], ms[k], h, bus.Quotient, bus.Reminder, e.q, e.r);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   qs[4]  = '{13, 14, 1, 0};
        int   ms[4]  = '{4, 5, 1, 6};
        int   eq[4]  = '{3, 2, 1, 0};
        int   er[4]  = '{1, 4, 0, 0};
        foreach (qs[k]) begin
            @(negedge clk);
            drive(qs[k], ms[k]);
            push_expected(qs[k], ms[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.Quotient !== e.q || bus.Reminder !== e.r ||
                e.q !== 8'(eq[k]) || e.r !== 8'(er[k])) begin
                n_fail++;
                $display("FAIL back_to_back %0d/%0d: got %h/%h expected %h/%h", qs[k], ms[k], bus.Quotient, bus.Reminder, 8'(eq[k]), 8'(er[k]));
            end
        end
    endtask

    task automatic test_exhaustive();
        exp_t e;
        for (int qv = 0; qv < 16; qv++) begin
            for (int mv = 0; mv < 16; mv++) begin
                @(negedge clk);
                drive(qv, mv);
                push_expected(qv, mv);
                @(posedge clk); #1;
                e = sb.pop_front();
                n_checks++;
                if (bus.Quotient !== e.q || bus.Reminder !== e.r) begin
                    n_fail++;
                    $display("FAIL exhaustive %0d/%0d: got %h/%h expected %h/%h", qv, mv, bus.Quotient, bus.Reminder, e.q, e.r);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        drive(13, 4);
        push_expected(13, 4);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.Quotient !== e.q || bus.Reminder !== e.r) begin
            n_fail++;
            $display("FAIL async_pre: got %h/%h expected %h/%h", bus.Quotient, bus.Reminder, e.q, e.r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.Quotient !== 8'h00 || bus.Reminder !== 8'h00) begin
            n_fail++;
            $display("FAIL async_assert: got %h/%h expected 00/00", bus.Quotient, bus.Reminder);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.Quotient !== 8'h00 || bus.Reminder !== 8'h00) begin
            n_fail++;
            $display("FAIL async_hold: got %h/%h expected 00/00", bus.Quotient, bus.Reminder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(14, 5);
        push_expected(14, 5);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.Quotient !== e.q || bus.Reminder !== e.r) begin
            n_fail++;
            $display("FAIL async_recover: got %h/%h expected %h/%h", bus.Quotient, bus.Reminder, e.q, e.r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_div_by_zero();
        test_reference();
        test_back_to_back();
        test_exhaustive();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
